// File: rtl/vec_regfile_sb.sv
// Vector register file: 2^AW x VLEN, NRD combinational read ports, two element-masked
// write ports with port-1 priority, optional write-to-read bypass, and a per-register pending scoreboard.
module vec_regfile_sb #(
    parameter int AW     = 5,
    parameter int ELEN   = 32,
    parameter int LANES  = 4,
    parameter int NRD    = 4,
    parameter int BYPASS = 1,
    localparam int VLEN  = ELEN * LANES,
    localparam int NREG  = 2 ** AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*AW-1:0]     ra,
    output logic [NRD*VLEN-1:0]   rd,
    output logic [NRD-1:0]        rbusy,
    input  logic                  we0,
    input  logic [AW-1:0]         wa0,
    input  logic [LANES-1:0]      wm0,
    input  logic [VLEN-1:0]       wd0,
    input  logic                  wlast0,
    input  logic                  we1,
    input  logic [AW-1:0]         wa1,
    input  logic [LANES-1:0]      wm1,
    input  logic [VLEN-1:0]       wd1,
    input  logic                  wlast1,
    input  logic                  rsv_en,
    input  logic [AW-1:0]         rsv_addr,
    output logic                  rsv_stall
);

    logic [NREG-1:0][VLEN-1:0] mem;
    logic [NREG-1:0]           pending;
    logic                      rsv_ok;

    assign rsv_stall = rsv_en && (rsv_addr != '0) && pending[rsv_addr];
    assign rsv_ok    = rsv_en && (rsv_addr != '0) && !pending[rsv_addr];

    // Register 0 is never written and never reserved, so it stays at its reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem     <= '0;
            pending <= '0;
        end else begin
            if (rsv_ok)
                pending[rsv_addr] <= 1'b1;
            if (we0 && wlast0 && (wa0 != '0))
                pending[wa0] <= 1'b0;
            if (we1 && wlast1 && (wa1 != '0))
                pending[wa1] <= 1'b0;
            for (int e = 0; e < LANES; e++) begin
                if (we0 && wm0[e] && (wa0 != '0))
                    mem[wa0][e*ELEN +: ELEN] <= wd0[e*ELEN +: ELEN];
                // Later assignment gives port 1 priority on overlapping elements.
                if (we1 && wm1[e] && (wa1 != '0))
                    mem[wa1][e*ELEN +: ELEN] <= wd1[e*ELEN +: ELEN];
            end
        end
    end

    always_comb begin
        rd    = '0;
        rbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            for (int e = 0; e < LANES; e++) begin
                rd[i*VLEN + e*ELEN +: ELEN] = mem[ra[i*AW +: AW]][e*ELEN +: ELEN];
                if (BYPASS != 0) begin
                    if (we0 && wm0[e] && (wa0 == ra[i*AW +: AW]))
                        rd[i*VLEN + e*ELEN +: ELEN] = wd0[e*ELEN +: ELEN];
                    if (we1 && wm1[e] && (wa1 == ra[i*AW +: AW]))
                        rd[i*VLEN + e*ELEN +: ELEN] = wd1[e*ELEN +: ELEN];
                end
            end
            // Forced zero also masks any bypass of an ignored write to register 0.
            if (ra[i*AW +: AW] == '0)
                rd[i*VLEN +: VLEN] = '0;
            rbusy[i] = pending[ra[i*AW +: AW]];
        end
    end

endmodule

// File: tb/tb_vec_regfile_sb.sv
// Scoreboard bench for vec_regfile_sb: driver pushes expected read data, busy bits and stall
// from a lane-level reference model; a negedge monitor pops and compares.
module tb_vec_regfile_sb;
    localparam int AW     = 5;
    localparam int ELEN   = 32;
    localparam int LANES  = 4;
    localparam int NRD    = 4;
    localparam int BYPASS = 1;
    localparam int VLEN   = ELEN * LANES;
    localparam int NREG   = 2 ** AW;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*VLEN-1:0] rd;
    logic [NRD-1:0]      rbusy;
    logic                we0, wlast0, we1, wlast1, rsv_en;
    logic [AW-1:0]       wa0, wa1, rsv_addr;
    logic [LANES-1:0]    wm0, wm1;
    logic [VLEN-1:0]     wd0, wd1;
    logic                rsv_stall;

    always #5 clk = ~clk;

    vec_regfile_sb #(.AW(AW), .ELEN(ELEN), .LANES(LANES), .NRD(NRD), .BYPASS(BYPASS)) dut (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd), .rbusy(rbusy),
        .we0(we0), .wa0(wa0), .wm0(wm0), .wd0(wd0), .wlast0(wlast0),
        .we1(we1), .wa1(wa1), .wm1(wm1), .wd1(wd1), .wlast1(wlast1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_stall(rsv_stall)
    );

    // what: 0 = rd of port, 1 = rbusy of port, 2 = rsv_stall
    typedef struct {
        int              cyc;
        string           name;
        int              what;
        int              port;
        logic [VLEN-1:0] exp;
    } item_t;

    item_t sbq[$];
    int    cyc_cnt = 0;
    int    n_cmp = 0;
    int    n_bad = 0;

    logic [ELEN-1:0] mreg [NREG][LANES];
    bit              mpend [NREG];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        item_t           it;
        logic [VLEN-1:0] got;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].cyc <= cyc_cnt) begin
                it = sbq.pop_front();
                case (it.what)
                    0:       got = rd[it.port*VLEN +: VLEN];
                    1:       got = VLEN'(rbusy[it.port]);
                    default: got = VLEN'(rsv_stall);
                endcase
                n_cmp++;
                if (it.cyc != cyc_cnt || got !== it.exp) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d port=%0d got=%h want=%h", it.name, it.cyc, it.port, got, it.exp);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic push(input string name, input int what, input int port, input logic [VLEN-1:0] exp);
        item_t it;
        it.cyc  = cyc_cnt;
        it.name = name;
        it.what = what;
        it.port = port;
        it.exp  = exp;
        sbq.push_back(it);
    endtask

    // Value element e of register a will hold after this cycle's writes.
    function automatic logic [ELEN-1:0] nxt(input int a, input int e);
        if (a == 0) return '0;
        if (we1 && wm1[e] && int'(wa1) == a) return wd1[e*ELEN +: ELEN];
        if (we0 && wm0[e] && int'(wa0) == a) return wd0[e*ELEN +: ELEN];
        return mreg[a][e];
    endfunction

    function automatic logic [VLEN-1:0] view(input int a);
        logic [VLEN-1:0] v;
        v = '0;
        for (int e = 0; e < LANES; e++)
            v[e*ELEN +: ELEN] = (a == 0) ? '0 : (BYPASS != 0) ? nxt(a, e) : mreg[a][e];
        return v;
    endfunction

    task automatic step(input bit chk);
        logic [ELEN-1:0] tmp [NREG][LANES];
        bit              acc;
        int              a;
        if (chk) begin
            for (int p = 0; p < NRD; p++) begin
                a = int'(ra[p*AW +: AW]);
                push("model_rd", 0, p, view(a));
                push("model_busy", 1, p, VLEN'(a != 0 && mpend[a]));
            end
            push("model_stall", 2, 0, VLEN'(rsv_en && rsv_addr != 0 && mpend[rsv_addr]));
        end
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                mpend[r] = 1'b0;
                for (int e = 0; e < LANES; e++) mreg[r][e] = '0;
            end
        end else begin
            acc = rsv_en && rsv_addr != 0 && !mpend[rsv_addr];
            for (int r = 0; r < NREG; r++)
                for (int e = 0; e < LANES; e++) tmp[r][e] = nxt(r, e);
            mreg = tmp;
            if (acc) mpend[rsv_addr] = 1'b1;
            if (we0 && wlast0) mpend[wa0] = 1'b0;
            if (we1 && wlast1) mpend[wa1] = 1'b0;
            mpend[0] = 1'b0;
        end
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; ra = '0;
        we0 = 1'b0; wa0 = '0; wm0 = '0; wd0 = '0; wlast0 = 1'b0;
        we1 = 1'b0; wa1 = '0; wm1 = '0; wd1 = '0; wlast1 = 1'b0;
        rsv_en = 1'b0; rsv_addr = '0;
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) begin
            mpend[r] = 1'b0;
            for (int e = 0; e < LANES; e++) mreg[r][e] = '0;
        end
        idle();
        rst = 1'b1;
        step(1'b0);
        step(1'b1);
        rst = 1'b0;

        for (int a = 0; a < NREG; a++) begin
            for (int p = 0; p < NRD; p++) begin
                ra[p*AW +: AW] = AW'(a);
                push("reset_rd", 0, p, '0);
                push("reset_busy", 1, p, '0);
            end
            step(1'b1);
        end

        idle();
        we0 = 1'b1; wa0 = 5'd3; wm0 = 4'b1111;
        wd0 = 128'h44444444_33333333_22222222_11111111;
        step(1'b1);
        wm0 = 4'b0010; wd0 = {4{32'hAAAAAAAA}};
        step(1'b1);
        idle(); ra[0 +: AW] = 5'd3;
        push("partial_mask", 0, 0, 128'h44444444_33333333_AAAAAAAA_11111111);
        step(1'b1);

        idle();
        we0 = 1'b1; wa0 = 5'd5; wm0 = 4'b1100; wd0 = {4{32'h11111111}};
        we1 = 1'b1; wa1 = 5'd5; wm1 = 4'b0110; wd1 = {4{32'h22222222}};
        ra[AW +: AW] = 5'd5;
        push("dual_bypass", 0, 1, 128'h11111111_22222222_22222222_00000000);
        step(1'b1);
        idle(); ra[AW +: AW] = 5'd5;
        push("dual_stored", 0, 1, 128'h11111111_22222222_22222222_00000000);
        step(1'b1);

        idle();
        rsv_en = 1'b1; rsv_addr = 5'd7;
        push("rsv_first", 2, 0, '0);
        step(1'b1);
        ra[0 +: AW] = 5'd7;
        push("rsv_busy", 1, 0, 1);
        push("rsv_again", 2, 0, 1);
        step(1'b1);
        we1 = 1'b1; wa1 = 5'd7; wm1 = 4'b0001; wd1 = {4{32'h7777_0007}}; wlast1 = 1'b1;
        push("rsv_clear_stall", 2, 0, 1);
        step(1'b1);
        we1 = 1'b0; wlast1 = 1'b0;
        push("rsv_retry", 2, 0, '0);
        step(1'b1);
        rsv_en = 1'b0;
        push("rsv_retry_busy", 1, 0, 1);
        step(1'b1);

        idle();
        we0 = 1'b1; wa0 = '0; wm0 = 4'hF; wd0 = '1;
        we1 = 1'b1; wa1 = '0; wm1 = 4'hF; wd1 = '1;
        rsv_en = 1'b1; rsv_addr = '0;
        push("r0_bypass", 0, 0, '0);
        push("r0_stall", 2, 0, '0);
        step(1'b1);
        idle();
        push("r0_rd", 0, 0, '0);
        push("r0_busy", 1, 0, '0);
        step(1'b1);

        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int p = 0; p < NRD; p++)
                ra[p*AW +: AW] = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, NREG-1) : $urandom_range(0, 9));
            we0 = 1'(($urandom_range(0, 1))); wa0 = AW'($urandom_range(0, 9));
            wm0 = LANES'($urandom); wd0 = {$urandom, $urandom, $urandom, $urandom};
            wlast0 = 1'($urandom_range(0, 1));
            we1 = 1'(($urandom_range(0, 1))); wa1 = AW'($urandom_range(0, 9));
            wm1 = LANES'($urandom); wd1 = {$urandom, $urandom, $urandom, $urandom};
            wlast1 = 1'($urandom_range(0, 1));
            rsv_en = 1'($urandom_range(0, 1)); rsv_addr = AW'($urandom_range(0, 9));
            step(1'b1);
        end

        idle();
        we0 = 1'b1; wa0 = 5'd9; wm0 = 4'hF; wd0 = {$urandom, $urandom, $urandom, $urandom};
        rsv_en = 1'b1; rsv_addr = 5'd9;
        step(1'b1);
        we0 = 1'b0; rsv_addr = 5'd10;
        step(1'b1);
        rst = 1'b1;
        we0 = 1'b1; wa0 = 5'd9; wm0 = 4'hF; wd0 = '1;
        we1 = 1'b1; wa1 = 5'd11; wm1 = 4'hF; wd1 = '1;
        rsv_en = 1'b1; rsv_addr = 5'd12;
        step(1'b1);
        idle();
        ra = {5'd12, 5'd11, 5'd10, 5'd9};
        for (int p = 0; p < NRD; p++) begin
            push("midrst_rd", 0, p, '0);
            push("midrst_busy", 1, p, '0);
        end
        rsv_en = 1'b1; rsv_addr = 5'd9;
        push("midrst_stall", 2, 0, '0);
        step(1'b1);
        idle();
        step(1'b1);

        for (int k = 0; k < 20 && sbq.size() > 0; k++) @(negedge clk);
        if (sbq.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d items left, want 0", sbq.size());
        end
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
